// File: rtl/conv_sched.sv
// Frame scheduler for the convolution engine: sequences row loads, column
// shifts and engine enables per tile, tags real results and drains the pipeline.
module conv_sched #(
  parameter int width   = 1920,
  parameter int height  = 1080,
  parameter int numCol  = 10,
  parameter int pipeLat = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iStart,
  input  logic [2:0]  iMode,
  input  logic        iValid,
  output logic        oReq,
  output logic [10:0] oReqX,
  output logic [10:0] oReqY,
  output logic        oRowShift,
  output logic        oColShift,
  output logic        oEngEn,
  output logic        oValid,
  output logic        oBusy,
  output logic        oDone
);

  localparam int DW = (pipeLat > 1) ? $clog2(pipeLat) : 1;
  localparam logic [4:0]  NCOL  = 5'(numCol);
  localparam logic [11:0] WIDTH = 12'(width);
  localparam logic [11:0] HGT   = 12'(height);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN} state_t;

  state_t               state_q, state_d;
  logic [3:0]           kw_q, kw_d;
  logic [3:0]           kh_q, kh_d;
  logic [10:0]          x_q, x_d;
  logic [10:0]          y_q, y_d;
  logic [2:0]           row_cnt_q, row_cnt_d;
  logic [4:0]           pos_cnt_q, pos_cnt_d;
  logic [DW-1:0]        drain_cnt_q, drain_cnt_d;
  logic [pipeLat-1:0]   tag_q, tag_d;
  logic                 valid_q, valid_d;

  logic [3:0]  mode_kw, mode_kh;
  logic [4:0]  p_w;
  logic [11:0] wout, hout, rem_w, x_next;
  logic [4:0]  pt;
  logic        row_last, pos_last, drain_last, more_x, more_y;

  // Modes 6 and 7 fall through to the 7x7 kernel.
  always_comb begin
    mode_kw = 4'd7;
    mode_kh = 4'd7;
    case (iMode)
      3'd0: begin mode_kw = 4'd3; mode_kh = 4'd1; end
      3'd1: begin mode_kw = 4'd5; mode_kh = 4'd1; end
      3'd2: begin mode_kw = 4'd7; mode_kh = 4'd1; end
      3'd3: begin mode_kw = 4'd3; mode_kh = 4'd3; end
      3'd4: begin mode_kw = 4'd5; mode_kh = 4'd5; end
      default: begin mode_kw = 4'd7; mode_kh = 4'd7; end
    endcase
  end

  // Tile geometry for the latched kernel; the last tile of a row may be short.
  always_comb begin
    p_w        = NCOL - {1'b0, kw_q} + 5'd1;
    wout       = WIDTH - {8'd0, kw_q} + 12'd1;
    hout       = HGT - {8'd0, kh_q} + 12'd1;
    rem_w      = wout - {1'b0, x_q};
    pt         = (rem_w < {7'd0, p_w}) ? rem_w[4:0] : p_w;
    x_next     = {1'b0, x_q} + {7'd0, p_w};
    more_x     = x_next < wout;
    more_y     = {1'b0, y_q} < (hout - 12'd1);
    row_last   = {1'b0, row_cnt_q} == (kh_q - 4'd1);
    pos_last   = pos_cnt_q == (pt - 5'd1);
    drain_last = drain_cnt_q == DW'(pipeLat - 1);
  end

  always_comb begin
    state_d     = state_q;
    kw_d        = kw_q;
    kh_d        = kh_q;
    x_d         = x_q;
    y_d         = y_q;
    row_cnt_d   = row_cnt_q;
    pos_cnt_d   = pos_cnt_q;
    drain_cnt_d = drain_cnt_q;
    oReq        = 1'b0;
    oColShift   = 1'b0;
    oEngEn      = 1'b0;
    oDone       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          state_d   = S_LOAD;
          kw_d      = mode_kw;
          kh_d      = mode_kh;
          x_d       = 11'd0;
          y_d       = 11'd0;
          row_cnt_d = 3'd0;
          pos_cnt_d = 5'd0;
        end
      end
      S_LOAD: begin
        oReq = 1'b1;
        if (iValid) begin
          if (row_last) begin
            row_cnt_d = 3'd0;
            pos_cnt_d = 5'd0;
            state_d   = S_COMPUTE;
          end else begin
            row_cnt_d = row_cnt_q + 3'd1;
          end
        end
      end
      S_COMPUTE: begin
        oEngEn    = 1'b1;
        oColShift = !pos_last;
        if (pos_last) begin
          pos_cnt_d = 5'd0;
          if (more_x) begin
            x_d     = x_next[10:0];
            state_d = S_LOAD;
          end else if (more_y) begin
            x_d     = 11'd0;
            y_d     = y_q + 11'd1;
            state_d = S_LOAD;
          end else begin
            drain_cnt_d = '0;
            state_d     = S_DRAIN;
          end
        end else begin
          pos_cnt_d = pos_cnt_q + 5'd1;
        end
      end
      S_DRAIN: begin
        oEngEn = 1'b1;
        if (drain_last) begin
          oDone   = 1'b1;
          state_d = S_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Tags move in lockstep with the engine: a 1 marks a real window sample,
  // a 0 marks a flush bubble pushed during drain.
  always_comb begin
    tag_d = tag_q;
    if (oEngEn) begin
      tag_d    = tag_q << 1;
      tag_d[0] = (state_q == S_COMPUTE);
    end
    valid_d = oEngEn & tag_q[pipeLat-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      kw_q        <= 4'd3;
      kh_q        <= 4'd3;
      x_q         <= 11'd0;
      y_q         <= 11'd0;
      row_cnt_q   <= 3'd0;
      pos_cnt_q   <= 5'd0;
      drain_cnt_q <= '0;
      tag_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      kw_q        <= kw_d;
      kh_q        <= kh_d;
      x_q         <= x_d;
      y_q         <= y_d;
      row_cnt_q   <= row_cnt_d;
      pos_cnt_q   <= pos_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      tag_q       <= tag_d;
      valid_q     <= valid_d;
    end
  end

  assign oReqX     = x_q;
  assign oReqY     = y_q + {8'd0, row_cnt_q};
  assign oRowShift = oReq & iValid;
  assign oBusy     = (state_q != S_IDLE);
  assign oValid    = valid_q;

endmodule

// File: tb/tb_conv_sched.sv
// Bench for conv_sched on a 16x10 frame: request coordinates are checked
// against a queue built from raster traversal; per-frame counts are hand-derived.
module tb_conv_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iStart = 1'b0;
  logic [2:0]  iMode = 3'd0;
  logic        iValid = 1'b0;
  logic        oReq, oRowShift, oColShift, oEngEn, oValid, oBusy, oDone;
  logic [10:0] oReqX, oReqY;

  logic [21:0] exp_q[$];
  logic [21:0] exp_w;
  int cmp_cnt = 0;
  int fail_cnt = 0;
  int hs_cnt, val_cnt, cs_cnt, done_cnt;

  conv_sched #(.width(16), .height(10), .numCol(10), .pipeLat(6)) dut (
    .clk(clk), .reset(reset), .iStart(iStart), .iMode(iMode), .iValid(iValid),
    .oReq(oReq), .oReqX(oReqX), .oReqY(oReqY), .oRowShift(oRowShift),
    .oColShift(oColShift), .oEngEn(oEngEn), .oValid(oValid), .oBusy(oBusy),
    .oDone(oDone)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Raster traversal of a 16x10 frame, one entry per row-word handshake.
  task automatic push_model(input logic [2:0] mode);
    int kw, kh, wo, ho, p;
    case (mode)
      3'd0: begin kw = 3; kh = 1; end
      3'd1: begin kw = 5; kh = 1; end
      3'd2: begin kw = 7; kh = 1; end
      3'd3: begin kw = 3; kh = 3; end
      3'd4: begin kw = 5; kh = 5; end
      default: begin kw = 7; kh = 7; end
    endcase
    wo = 16 - kw + 1;
    ho = 10 - kh + 1;
    p  = 10 - kw + 1;
    for (int y = 0; y < ho; y++)
      for (int x = 0; x < wo; x += p)
        for (int r = 0; r < kh; r++)
          exp_q.push_back({11'(x), 11'(y + r)});
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (oRowShift) begin
        hs_cnt++;
        check("rowshift_needs_req", {31'd0, oReq}, 32'd1);
        if (exp_q.size() == 0) begin
          cmp_cnt++;
          fail_cnt++;
          $display("FAIL req_coord: handshake x=%0d y=%0d with nothing expected", oReqX, oReqY);
        end else begin
          exp_w = exp_q.pop_front();
          check("req_x", {21'd0, oReqX}, {21'd0, exp_w[21:11]});
          check("req_y", {21'd0, oReqY}, {21'd0, exp_w[10:0]});
        end
      end
      if (oColShift) begin
        cs_cnt++;
        check("colshift_with_en", {31'd0, oEngEn}, 32'd1);
      end
      if (oValid) val_cnt++;
      if (oDone) done_cnt++;
    end
  end

  // pat: 0 = iValid held high, 1 = toggling, 2 = 20-cycle stall at the third tile load
  task automatic run_frame(input logic [2:0] mode, input int pat, input int e_hs,
                           input int e_val, input int e_cs, input bit busy_pulse);
    int  loads;
    int  stall_left;
    bit  prev_req;
    bit  done;
    push_model(mode);
    hs_cnt = 0; val_cnt = 0; cs_cnt = 0; done_cnt = 0;
    @(posedge clk); #1;
    iStart = 1'b1; iMode = mode; iValid = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0; iMode = 3'd0;
    check("start_to_req", {31'd0, oReq}, 32'd1);
    loads = 1; prev_req = 1'b1; stall_left = 0; done = 1'b0;
    for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
      if (busy_pulse && cyc == 3) begin
        iStart = 1'b1;
        iMode  = 3'd3;
      end else begin
        iStart = 1'b0;
      end
      if (oReq && !prev_req) begin
        loads++;
        if (pat == 2 && loads == 3) stall_left = 20;
      end
      prev_req = oReq;
      case (pat)
        1: iValid = ~iValid;
        2: begin
          if (stall_left > 0) begin
            if (stall_left < 20) check("stall_no_valid", {31'd0, oValid}, 32'd0);
            iValid = 1'b0;
            stall_left--;
          end else begin
            iValid = 1'b1;
          end
        end
        default: iValid = 1'b1;
      endcase
      if (oDone) done = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    iStart = 1'b0;
    if (!done) begin
      cmp_cnt++;
      fail_cnt++;
      $display("FAIL frame_timeout: mode %0d no done within budget", mode);
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      return;
    end
    @(posedge clk); #1;
    check("last_valid_after_done", {31'd0, oValid}, 32'd1);
    check("idle_after_done", {31'd0, oBusy}, 32'd0);
    @(negedge clk); #1;
    check("handshakes", hs_cnt, e_hs);
    check("valid_count", val_cnt, e_val);
    check("colshift_count", cs_cnt, e_cs);
    check("done_count", done_cnt, 1);
    check("queue_drained", exp_q.size(), 0);
    @(posedge clk); #1;
    check("valid_low_after", {31'd0, oValid}, 32'd0);
  endtask

  initial begin
    int en_seen;
    #1;
    check("reset_outputs", {oReq, oRowShift, oColShift, oEngEn, oValid, oBusy, oDone, oReqX, oReqY},
          29'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    run_frame(3'd3, 0, 48, 112, 96, 1'b0);
    run_frame(3'd5, 0, 84, 40, 28, 1'b0);
    run_frame(3'd0, 1, 20, 140, 120, 1'b0);
    run_frame(3'd5, 2, 84, 40, 28, 1'b0);

    // Asynchronous reset in the middle of a 3x3 frame's compute phase.
    push_model(3'd3);
    @(posedge clk); #1;
    iStart = 1'b1; iMode = 3'd3; iValid = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0;
    en_seen = 0;
    for (int cyc = 0; cyc < 500 && en_seen < 20; cyc++) begin
      if (oEngEn) en_seen++;
      if (en_seen < 20) begin
        @(posedge clk); #1;
      end
    end
    check("reached_compute", en_seen, 20);
    #3 reset = 1'b1;
    #1;
    check("midframe_reset_outputs",
          {oReq, oRowShift, oColShift, oEngEn, oValid, oBusy, oDone, oReqX, oReqY}, 29'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    run_frame(3'd4, 0, 60, 72, 60, 1'b0);
    run_frame(3'd7, 0, 84, 40, 28, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
